// File: rtl/mmio_uart_tx.sv
// MMIO console transmitter: FIFO-buffered 8N1 serialiser (even parity bit when UART_TX_PARITY_EN is defined).
// First start bit two edges after the store; a store into a full FIFO is dropped and sets sticky overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic        full;
  logic        empty;
  logic        frame_active;
  logic        baud_end;
  logic        pop;
  logic        push_req;
  logic        push;
  logic        ovf_clr;
  logic [7:0]  head;
  logic [3:0]  cnt_sat;
  logic [31:0] status;
  logic        unused_bits;

  assign hit          = (addr[31:3] == BASE_ADDR[31:3]);
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign frame_active = (state != S_IDLE);
  assign busy         = frame_active | ~empty;
  assign baud_end     = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign head         = mem[rptr];

  // The transmitter takes the head byte when idle, or as the stop bit ends so frames abut.
  assign pop      = ~empty & ((state == S_IDLE) | ((state == S_STOP) & baud_end));
  assign push_req = w_en & hit & ~addr[2];
  assign push     = push_req & (~full | pop);
  assign ovf_clr  = w_en & hit & addr[2] & wdata[3];

  assign cnt_sat = (count > CNT_W'(15)) ? 4'd15 : 4'(count);
  assign status  = {23'd0, PAR_EN, cnt_sat, overflow, frame_active, empty, full};
  assign rdata   = (hit && r_en && addr[2]) ? status : 32'd0;

  assign unused_bits = &{1'b0, addr[1:0], wdata[31:8]};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)             overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state <= S_START;
            shreg <= head;
`ifdef UART_TX_PARITY_EN
            par   <= ^head;
`endif
            baud  <= '0;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= S_DATA;
            tx      <= shreg[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            state <= S_STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              state <= S_START;
              shreg <= head;
`ifdef UART_TX_PARITY_EN
              par   <= ^head;
`endif
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: serial waveforms and STATUS values predicted from frame rules and a FIFO occupancy model.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];
  bit got_q[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .w_en(w_en), .r_en(r_en), .wdata(wdata),
    .hit(hit), .rdata(rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status_of(input int cnt, input logic ovf, input logic act);
    int s;
    s = (cnt > 15) ? 15 : cnt;
    return {23'd0, PAR, 4'(s), ovf, act, (cnt == 0), (cnt == DEPTH)};
  endfunction

  // Expected line level for one whole frame, one entry per clock cycle.
  task automatic add_frame(input logic [7:0] b);
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (CPB) exp_q.push_back(^b);
`endif
    repeat (CPB) exp_q.push_back(1'b1);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    addr = a; r_en = 1'b1;
    #1 v = rdata;
    r_en = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    while (waited < 64 && tx !== 1'b0) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic capture_wave(input int n);
    got_q.delete();
    got_q.push_back(tx);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      got_q.push_back(tx);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst = 1'b1;
    read_reg(BASE + 4, v);
    tests++; if (v !== status_of(0, 0, 0)) begin fails++; $display("FAIL reset_status got %h want %h", v, status_of(0, 0, 0)); end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    int w, d;
    exp_q.delete(); add_frame(b);
    store(BASE, {24'hFFFFFF, b});
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_early_start got %b want 1", tx); end
    wait_start(w);
    tests++; if (w !== 1) begin fails++; $display("FAIL single_latency got %0d want 1 extra edge", w); end
    capture_wave(FRAME);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL single_wave byte %h bad cycle %0d want %b", b, d, exp_q[d]); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_last got %b want 1", busy); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL single_end busy %b tx %b want 0 1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    int w, d;
    exp_q.delete(); add_frame(8'h41); add_frame(8'h42);
    store(BASE, 32'h41);
    store(BASE + 1, 32'h42);
    wait_start(w);
    tests++; if (w !== 0) begin fails++; $display("FAIL b2b_latency got %0d want 0", w); end
    capture_wave(2 * FRAME);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL b2b_wave bad cycle %0d want %b", d, exp_q[d]); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      logic [7:0] bytes [5];
      int gaps [5];
      int w, d;
      logic [31:0] v;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
        bytes[i] = 8'($urandom_range(0, 255));
        gaps[i]  = $urandom_range(0, 2);
        add_frame(bytes[i]);
      end
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            store(BASE + 32'($urandom_range(0, 3)), {24'($urandom), bytes[i]});
            repeat (gaps[i]) @(negedge clk);
          end
        end
        begin
          wait_start(w);
          tests++; if (tx !== 1'b0) begin fails++; $display("FAIL random_start_timeout round %0d tx %b want 0", r, tx); end
          capture_wave(5 * FRAME);
        end
      join
      d = first_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL random_wave round %0d bad cycle %0d want %b", r, d, exp_q[d]); end
      @(negedge clk);
      read_reg(BASE + 4, v);
      tests++; if (v !== status_of(0, 0, 0)) begin fails++; $display("FAIL random_status got %h want %h", v, status_of(0, 0, 0)); end
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] acc [$];
    logic [7:0] b;
    logic [31:0] v;
    int buffered, w, d;
    logic ovf;
    buffered = 0; ovf = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          b = 8'($urandom_range(0, 255));
          // the first byte goes straight to the idle transmitter
          if (i == 0) acc.push_back(b);
          else if (buffered < DEPTH) begin acc.push_back(b); buffered++; end
          else ovf = 1'b1;
          store(BASE, {24'd0, b});
        end
        read_reg(BASE + 4, v);
        tests++; if (v !== status_of(buffered, ovf, 1)) begin fails++; $display("FAIL fill_status got %h want %h", v, status_of(buffered, ovf, 1)); end
        store(BASE + 4, 32'h8);
        read_reg(BASE + 4, v);
        tests++; if (v !== status_of(buffered, 0, 1)) begin fails++; $display("FAIL ovf_clear got %h want %h", v, status_of(buffered, 0, 1)); end
        // land a store on the edge where the second frame starts: pop frees a slot
        repeat (FRAME - 10) @(negedge clk);
        acc.push_back(8'hEE);
        store(BASE, 32'hEE);
        read_reg(BASE + 4, v);
        tests++; if (v !== status_of(buffered, 0, 1)) begin fails++; $display("FAIL full_push_pop got %h want %h", v, status_of(buffered, 0, 1)); end
      end
      begin
        wait_start(w);
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL fill_start_timeout tx %b want 0", tx); end
        capture_wave(10 * FRAME);
      end
    join
    foreach (acc[i]) add_frame(acc[i]);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL fill_wave bad cycle %0d want %b", d, exp_q[d]); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fill_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic [31:0] v;
    int lows;
    b = 8'h34;
    store(BASE, {24'd0, b});
    store(BASE, 32'h5A);
    repeat (1 + 4 * CPB) @(negedge clk);
    tests++; if (tx !== b[3]) begin fails++; $display("FAIL mid_bit3 got %b want %b", tx, b[3]); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL mid_reset tx %b busy %b want 1 0", tx, busy); end
    rst = 1'b1;
    read_reg(BASE + 4, v);
    tests++; if (v !== status_of(0, 0, 0)) begin fails++; $display("FAIL mid_status got %h want %h", v, status_of(0, 0, 0)); end
    lows = 0;
    repeat (2 * FRAME) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) lows++; end
    tests++; if (lows != 0) begin fails++; $display("FAIL mid_discard got %0d active cycles want 0", lows); end
    test_single_frame(8'($urandom_range(0, 255)));
  endtask

  task automatic test_no_hit();
    logic [31:0] al [5];
    logic [31:0] v;
    int act;
    al = '{32'h0000_1000, 32'h0000_1007, 32'h0000_1008, 32'h0000_0FFF, 32'h8000_1000};
    foreach (al[i]) begin
      addr = al[i]; #1;
      tests++; if (hit !== ((al[i] >> 3) == (BASE >> 3))) begin fails++; $display("FAIL hit addr %h got %b", al[i], hit); end
    end
    read_reg(BASE, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL txdata_read got %h want 0", v); end
    read_reg(BASE + 6, v);
    tests++; if (v !== status_of(0, 0, 0)) begin fails++; $display("FAIL status_alias got %h want %h", v, status_of(0, 0, 0)); end
    read_reg(32'h0000_2004, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL miss_read got %h want 0", v); end
    addr = BASE + 4; #1;
    tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL no_ren_read got %h want 0", rdata); end
    store(32'h0000_2000, 32'h55);
    store(BASE + 8, 32'hFF);
    store(BASE + 4, 32'hFF);
    act = 0;
    repeat (10) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) act++; end
    tests++; if (act != 0) begin fails++; $display("FAIL miss_store got %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset();
    test_no_hit();
    test_single_frame(8'h55);
    test_single_frame(8'h07);
    test_back_to_back();
    test_random(3);
    test_fill_overflow();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
